// File: rtl/spi_shift_ctrl.sv
//------------------------------------------------------------------------------
// spi_shift_ctrl : SPI mode-0 master shift engine driving an external SCK generator
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_shift_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter bit MSB_FIRST    = 1'b1,
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  spi_clk_en_o,
  input  logic                  spi_clk_i,
  output logic                  spi_cs_n_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i
);

  localparam int BW      = $clog2(DATA_WIDTH + 1);
  localparam int CNT_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [BW-1:0] BITS       = BW'(DATA_WIDTH);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_XFER  = 2'd2,
    S_TRAIL = 2'd3
  } state_e;

  state_e                state_q,   state_d;
  logic [CW-1:0]         cnt_q,     cnt_d;
  logic [BW-1:0]         bitcnt_q,  bitcnt_d;
  logic                  sck_q,     sck_d;
  logic [DATA_WIDTH-1:0] tx_sr_q,   tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q,   rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  cs_n_q,    cs_n_d;
  logic                  mosi_q,    mosi_d;
  logic                  clk_en_q,  clk_en_d;

  logic w_rise;
  logic w_fall;

  // sck_q is held low outside XFER, so these only fire on real generator edges
  assign w_rise = spi_clk_i & ~sck_q;
  assign w_fall = ~spi_clk_i & sck_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      sck_q      <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      clk_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      sck_q      <= sck_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      clk_en_q   <= clk_en_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitcnt_d   = bitcnt_q;
    sck_d      = 1'b0;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    clk_en_d   = clk_en_q;

    case (state_q)
      S_IDLE: begin
        if (tx_valid_i) begin
          tx_sr_d  = tx_data_i;
          rx_sr_d  = '0;
          bitcnt_d = '0;
          cnt_d    = '0;
          cs_n_d   = 1'b0;
          if (MSB_FIRST) begin
            mosi_d = tx_data_i[DATA_WIDTH-1];
          end else begin
            mosi_d = tx_data_i[0];
          end
          state_d = S_LEAD;
        end
      end

      S_LEAD: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d    = '0;
          clk_en_d = 1'b1;
          state_d  = S_XFER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_XFER: begin
        sck_d = spi_clk_i;
        if (w_rise) begin
          if (MSB_FIRST) begin
            rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], spi_miso_i};
          end else begin
            rx_sr_d = {spi_miso_i, rx_sr_q[DATA_WIDTH-1:1]};
          end
          bitcnt_d = bitcnt_q + 1'b1;
        end else if (w_fall) begin
          if (bitcnt_q < BITS) begin
            if (MSB_FIRST) begin
              tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
              mosi_d  = tx_sr_q[DATA_WIDTH-2];
            end else begin
              tx_sr_d = {1'b0, tx_sr_q[DATA_WIDTH-1:1]};
              mosi_d  = tx_sr_q[1];
            end
          end else begin
            // Last falling edge: SCK is parked low, stop the generator
            clk_en_d = 1'b0;
            sck_d    = 1'b0;
            cnt_d    = '0;
            state_d  = S_TRAIL;
          end
        end
      end

      S_TRAIL: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d      = '0;
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx_ready_o   = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign spi_clk_en_o = clk_en_q;
  assign spi_cs_n_o   = cs_n_q;
  assign spi_mosi_o   = mosi_q;

endmodule

`default_nettype wire
